// File: rtl/fxp_phase_acc.sv
// Wrapped fixed-point phase accumulator. It produces a counted or continuous stream of
// signed angles in [-PI, PI) with a valid/ready handshake. Optional o_wrap output: FXP_PHASE_ACC_WRAP_EN.
module fxp_phase_acc #(
  parameter int WOI = 4,
  parameter int WOF = 12,
  parameter int WC  = 16
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WOI+WOF-1:0]   step,
  input  logic [WOI+WOF-1:0]   phase0,
  input  logic [WC-1:0]        count,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   o_phase,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
`ifdef FXP_PHASE_ACC_WRAP_EN
  ,
  output logic                 o_wrap
`endif
);

  localparam int W      = WOI + WOF;
  localparam int PI_INT = $rtoi(3.141592653589793 * (2.0 ** WOF) + 0.5);
  localparam logic signed [W:0] PI     = PI_INT[W:0];
  localparam logic signed [W:0] TWO_PI = PI <<< 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_step;
  logic [WC-1:0]   r_remaining;
  logic            r_cont;
  logic            r_valid;
  logic            r_done;
  logic            r_cfg_err;
`ifdef FXP_PHASE_ACC_WRAP_EN
  logic            r_wrap;
`endif

  logic signed [W:0] w_step_ext;
  logic signed [W:0] w_phase0_ext;
  logic signed [W:0] w_sum;
  logic              w_cfg_ok;
  logic              w_hs;
  logic              w_wrap_hi;
  logic              w_wrap_lo;
  logic [W-1:0]      w_next;

  // Extending by one bit keeps acc + step exact: both lie in [-PI, PI), and PI is below 2^(W-1).
  // NOTE: give every always_comb output a default before any branch so no latch is inferred.
  always_comb begin
    w_step_ext   = {step[W-1], step};
    w_phase0_ext = {phase0[W-1], phase0};
    w_cfg_ok     = (w_step_ext > -PI) && (w_step_ext < PI) &&
                   (w_phase0_ext >= -PI) && (w_phase0_ext < PI);
    w_hs         = r_valid & o_ready;
    w_sum        = {r_acc[W-1], r_acc} + {r_step[W-1], r_step};
    w_wrap_hi    = (w_sum >= PI);
    w_wrap_lo    = (w_sum < -PI);
    w_next       = W'(w_sum);
    if (w_wrap_hi)      w_next = W'(w_sum - TWO_PI);
    else if (w_wrap_lo) w_next = W'(w_sum + TWO_PI);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_step      <= '0;
      r_remaining <= '0;
      r_cont      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
`ifdef FXP_PHASE_ACC_WRAP_EN
      r_wrap      <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_state     <= S_RUN;
              r_acc       <= phase0;
              r_step      <= step;
              r_remaining <= count;
              r_cont      <= (count == '0);
              r_valid     <= 1'b1;
`ifdef FXP_PHASE_ACC_WRAP_EN
              r_wrap      <= 1'b0;
`endif
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_acc       <= w_next;
            r_remaining <= r_remaining - WC'(1);
`ifdef FXP_PHASE_ACC_WRAP_EN
            r_wrap      <= w_wrap_hi | w_wrap_lo;
`endif
          end
          // A stop does not cancel a handshake in the same cycle; that sample is still delivered.
          if (stop || (w_hs && !r_cont && (r_remaining == WC'(1)))) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_phase = r_acc;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign cfg_err = r_cfg_err;
`ifdef FXP_PHASE_ACC_WRAP_EN
  assign o_wrap  = r_wrap & r_valid;
`endif

endmodule

// File: tb/tb_fxp_phase_acc.sv
// Self-checking bench for fxp_phase_acc. Expected angles come from a modular-arithmetic model:
// phase0 + k*step folded into [-PI, PI).
module tb_fxp_phase_acc;

  localparam int W      = 16;
  localparam int WC     = 16;
  localparam int PI     = 12868;
  localparam int TWO_PI = 2 * PI;

  logic          rstn = 1'b0;
  logic          clk  = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [W-1:0]  step   = '0;
  logic [W-1:0]  phase0 = '0;
  logic [WC-1:0] count  = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [W-1:0]  o_phase;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef FXP_PHASE_ACC_WRAP_EN
  logic          o_wrap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fxp_phase_acc dut (
    .rstn    (rstn),
    .clk     (clk),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .phase0  (phase0),
    .count   (count),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_phase (o_phase),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
`ifdef FXP_PHASE_ACC_WRAP_EN
    ,
    .o_wrap  (o_wrap)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_signed(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Angle of sample k, computed directly as (phase0 + k*step) mod 2PI in [-PI, PI).
  function automatic logic [W-1:0] model_phase(input int p0, input int st, input int k);
    longint x;
    x = longint'(p0) + longint'(k) * longint'(st);
    x = ((x + PI) % TWO_PI + TWO_PI) % TWO_PI - PI;
    return x[W-1:0];
  endfunction

  function automatic logic model_wrap(input int p0, input int st, input int k);
    int raw;
    if (k == 0) return 1'b0;
    raw = to_signed(model_phase(p0, st, k - 1)) + st;
    return (raw >= PI) || (raw < -PI);
  endfunction

  task automatic do_start(input logic [W-1:0] p0, input logic [W-1:0] st, input logic [WC-1:0] cnt);
    phase0 = p0;
    step   = st;
    count  = cnt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_tests++; if (o_phase !== 16'h0000) begin n_fail++; $display("FAIL reset_phase got %h want 0000", o_phase); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
`ifdef FXP_PHASE_ACC_WRAP_EN
    n_tests++; if (o_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", o_wrap); end
`endif
    rstn = 1'b1;
    tick();
  endtask

  // Full-rate counted sequence against a fixed list of expected angles and wrap flags.
  task automatic test_directed(input string name, input logic [W-1:0] p0, input logic [W-1:0] st,
                               input int cnt, input logic [W-1:0] exp_ph[4], input logic exp_wr[4]);
    o_ready = 1'b1;
    do_start(p0, st, WC'(cnt));
    for (int k = 0; k < cnt; k++) begin
      n_tests++; if (o_valid !== 1'b1 || o_phase !== exp_ph[k]) begin
        n_fail++; $display("FAIL %s sample%0d got v=%b %h want v=1 %h", name, k, o_valid, o_phase, exp_ph[k]);
      end
`ifdef FXP_PHASE_ACC_WRAP_EN
      n_tests++; if (o_wrap !== exp_wr[k]) begin
        n_fail++; $display("FAIL %s wrap%0d got %b want %b", name, k, o_wrap, exp_wr[k]);
      end
`else
      if (exp_wr[k] === 1'bx) $display("%s: unexpected X in wrap table", name);
`endif
      tick();
    end
    n_tests++; if (done !== 1'b1 || busy !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s done_cycle got d=%b b=%b v=%b want d=1 b=1 v=0", name, done, busy, o_valid);
    end
    tick();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after got d=%b b=%b want d=0 b=0", name, done, busy);
    end
    o_ready = 1'b0;
  endtask

  task automatic test_backpressure_stop();
    o_ready = 1'b0;
    do_start(16'h0000, 16'h0100, '0);
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (o_valid !== 1'b1 || o_phase !== 16'h0000) begin
        n_fail++; $display("FAIL hold cycle%0d got v=%b %h want v=1 0000", c, o_valid, o_phase);
      end
      if (c == 1) begin
        start = 1'b1;
        step  = 16'h3244;
      end
      if (c == 3) o_ready = 1'b1;
      tick();
      start = 1'b0;
      if (c == 1) begin
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL start_while_busy cfg_err got %b want 0", cfg_err); end
      end
    end
    o_ready = 1'b0;
    n_tests++; if (o_valid !== 1'b1 || o_phase !== 16'h0100) begin
      n_fail++; $display("FAIL after_hold got v=%b %h want v=1 0100", o_valid, o_phase);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_tests++; if (done !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stop_done got d=%b v=%b b=%b want d=1 v=0 b=1", done, o_valid, busy);
    end
    tick();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL stop_idle got b=%b d=%b want b=0 d=0", busy, done);
    end
  endtask

  task automatic test_cfg_err();
    logic [W-1:0] bad_st[3] = '{16'h3244, 16'h0100, 16'hCDBC};
    logic [W-1:0] bad_p0[3] = '{16'h0000, 16'h3244, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_start(bad_p0[i], bad_st[i], 16'd4);
      n_tests++; if (cfg_err !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL cfg_err%0d pulse got e=%b b=%b v=%b want e=1 b=0 v=0", i, cfg_err, busy, o_valid);
      end
      tick();
      n_tests++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL cfg_err%0d after got e=%b b=%b want e=0 b=0", i, cfg_err, busy);
      end
    end
    // Largest legal step with phase0 exactly -PI is accepted.
    do_start(16'hCDBC, 16'h3243, 16'd3);
    n_tests++; if (cfg_err !== 1'b0 || busy !== 1'b1 || o_phase !== 16'hCDBC) begin
      n_fail++; $display("FAIL cfg_edge got e=%b b=%b %h want e=0 b=1 cdbc", cfg_err, busy, o_phase);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    o_ready = 1'b1;
    do_start(16'h1000, 16'h0200, '0);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_tests++; if (o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || o_phase !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset got v=%b b=%b d=%b %h want 0 0 0 0000", o_valid, busy, done, o_phase);
    end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_nodone got %b want 0", done); end
    do_start(16'h0400, 16'h0100, 16'd1);
    n_tests++; if (busy !== 1'b1 || o_valid !== 1'b1 || o_phase !== 16'h0400) begin
      n_fail++; $display("FAIL restart got b=%b v=%b %h want 1 1 0400", busy, o_valid, o_phase);
    end
    tick();
    tick();
    o_ready = 1'b0;
  endtask

  // Random counted sequences with random backpressure, checked against the modular model.
  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int p0  = int'($urandom_range(TWO_PI - 1)) - PI;
      int st  = int'($urandom_range(TWO_PI - 2)) - (PI - 1);
      int cnt = int'($urandom_range(8, 1));
      int k   = 0;
      int guard = 0;
      logic hs;
      logic [W-1:0] exp_ph;
      logic [W-1:0] p0_v = p0[W-1:0];
      logic [W-1:0] st_v = st[W-1:0];
      do_start(p0_v, st_v, WC'(cnt));
      while (k < cnt && guard < 200) begin
        exp_ph = model_phase(p0, st, k);
        n_tests++; if (o_valid !== 1'b1 || o_phase !== exp_ph) begin
          n_fail++; $display("FAIL rand%0d sample%0d got v=%b %h want v=1 %h", s, k, o_valid, o_phase, exp_ph);
        end
`ifdef FXP_PHASE_ACC_WRAP_EN
        n_tests++; if (o_wrap !== model_wrap(p0, st, k)) begin
          n_fail++; $display("FAIL rand%0d wrap%0d got %b want %b", s, k, o_wrap, model_wrap(p0, st, k));
        end
`endif
        hs = ($urandom_range(99) < 60);
        o_ready = hs;
        tick();
        if (hs) k++;
        guard++;
      end
      o_ready = 1'b0;
      n_tests++; if (guard >= 200) begin
        n_fail++; $display("FAIL rand%0d timeout got k=%0d want %0d", s, k, cnt);
      end
      n_tests++; if (done !== 1'b1 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d end got d=%b v=%b want d=1 v=0", s, done, o_valid);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed("seq_basic", 16'h0000, 16'h0800, 4,
                  '{16'h0000, 16'h0800, 16'h1000, 16'h1800}, '{1'b0, 1'b0, 1'b0, 1'b0});
    test_directed("wrap_pos", 16'h3000, 16'h0400, 2,
                  '{16'h3000, 16'hCF78, 16'h0000, 16'h0000}, '{1'b0, 1'b1, 1'b0, 1'b0});
    test_directed("wrap_neg", 16'hCE00, 16'hFC00, 2,
                  '{16'hCE00, 16'h2E88, 16'h0000, 16'h0000}, '{1'b0, 1'b1, 1'b0, 1'b0});
    test_backpressure_stop();
    test_cfg_err();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_phase_acc.md
FXP_PHASE_ACC -- requirements
Module: fxp_phase_acc

Interface
REQ-001 Parameter WOI, default 4, integer bits of signed angle/step (matches downstream fxp_sin WII).
REQ-002 Parameter WOF, default 12, fraction bits of signed angle/step (matches downstream fxp_sin WIF).
REQ-003 Parameter WC, default 16, width of sample counter.
REQ-004 Port rstn  input  1  synchronous active-low reset.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port start  input  1  one-cycle request to begin a sequence.
REQ-007 Port stop  input  1  request to end a running sequence early.
REQ-008 Port step  input  WOI+WOF  signed phase increment, sampled when start is accepted.
REQ-009 Port phase0  input  WOI+WOF  signed initial phase, sampled when start is accepted.
REQ-010 Port count  input  WC  number of samples; 0 = continuous until stop.
REQ-011 Port o_valid  output  1  o_phase holds a valid sample.
REQ-012 Port o_ready  input  1  consumer accepts sample this cycle.
REQ-013 Port o_phase  output  WOI+WOF  signed angle in [-PI, PI).
REQ-014 Port busy  output  1  sequence active (RUN or DONE).
REQ-015 Port done  output  1  one-cycle pulse at sequence end.
REQ-016 Port cfg_err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 PI shall be round(pi*2^WOF) (0x3244 at WOF=12); TWO_PI = 2*PI (0x6488).
REQ-018 States: IDLE, RUN, DONE.
REQ-019 IDLE: start with |step| < PI and -PI <= phase0 < PI -> RUN next cycle; acc <= phase0, remaining <= count.
REQ-020 IDLE: start with out-of-range step or phase0 -> stay IDLE, cfg_err = 1 for the next cycle only.
REQ-021 start while busy shall be ignored, with no cfg_err.
REQ-022 RUN: o_valid = 1, o_phase = acc; first sample is valid one cycle after start is accepted.
REQ-023 Handshake = o_valid & o_ready; only a handshake advances acc and decrements remaining.
REQ-024 Advance: sum = acc + step at WOI+WOF+1 bits; sum >= PI -> sum - TWO_PI; sum < -PI -> sum + TWO_PI; result truncated to WOI+WOF bits.
REQ-025 Without a handshake, o_phase and o_valid shall hold stable.
REQ-026 Handshake with count != 0 and remaining == 1 -> DONE.
REQ-027 stop in RUN -> DONE next cycle; a handshake in the same cycle counts as delivered.
REQ-028 DONE: o_valid = 0, done = 1 for exactly one cycle, busy = 1, then IDLE.
REQ-029 busy = 1 in RUN and DONE, 0 in IDLE.

Reset
REQ-030 rstn low at a clock edge -> IDLE, acc = 0, remaining = 0.
REQ-031 After reset: o_valid = 0, o_phase = 0, busy = 0, done = 0, cfg_err = 0, o_wrap = 0 when present.
REQ-032 Reset mid-RUN shall abort the sequence without a done pulse.

Configuration
REQ-033 Macro FXP_PHASE_ACC_WRAP_EN defined -> adds output o_wrap (1 bit); o_wrap = 1 while o_valid and o_phase came from a wrapped advance (REQ-024 correction applied).
REQ-034 FXP_PHASE_ACC_WRAP_EN undefined -> port o_wrap and its logic absent; all other behaviour identical.

Verification
REQ-035 phase0=0x0000, step=0x0800, count=4, o_ready=1 -> o_phase 0x0000, 0x0800, 0x1000, 0x1800 on consecutive cycles, then done pulse, busy low next cycle.
REQ-036 phase0=0x3000, step=0x0400, count=2 -> samples 0x3000 then 0xCF78; o_wrap=1 on second sample if enabled.
REQ-037 phase0=0xCE00, step=0xFC00, count=2 -> samples 0xCE00 then 0x2E88.
REQ-038 phase0=0x0000, step=0x0100, count=0, o_ready low 3 cycles after first sample -> 0x0000 held 4 cycles, then 0x0100; stop -> done in the following cycle.
REQ-039 start with step=0x3244 -> cfg_err pulse, busy stays 0; start with phase0=0x3244 -> same.
REQ-040 rstn low during RUN -> next cycle o_valid=0, busy=0, no done pulse; new start accepted afterwards.
